jtag_mailbox_dr: RTL and testbench
==================================

Name: jtag_mailbox_dr

Overview:
- Core-side responder behind the TAP: a user test-data register the host shifts command frames into and status or read data out of.
- A complete frame becomes a write or read request to core logic through a toggle req/ack handshake.
- Lives beside the bypass and boundary-scan registers; the instruction decoder supplies its gated clockDR and shiftDR.
- Completion of an outstanding request is polled by later DR scans.

Parameters:
ADDR_W, 8, core address width (>=1)
DATA_W, 16, core data width
FRAME_W, 2+ADDR_W+DATA_W, scan frame length (derived; do not override)

Ports:
clockDR  input  1  gated TCK from decoder; edges only during Capture-DR/Shift-DR
reset_bar  input  1  asynchronous, active-low reset (Test-Logic-Reset)
shiftDR  input  1  1 = shift edge, 0 = capture edge
scan_in  input  1  TDI
scan_out  output  1  shift_reg[0], to TDO mux
req_toggle  output  1  flips once per issued request
req_we  output  1  1 = write, 0 = read; stable while busy
req_addr  output  ADDR_W  request address; stable while busy
req_wdata  output  DATA_W  write data; stable while busy
ack_toggle  input  1  core flips once per completed request (core clock domain)
rdata  input  DATA_W  read data; stable from ack_toggle flip until next req_toggle flip

Behaviour:
- Clock and reset: all state updates on posedge clockDR. reset_bar low asynchronously clears every register: shift_reg, bit_cnt, req_toggle, req_we, req_addr, req_wdata, ack sync flops, rdata_reg, rd_valid, err, state = S_IDLE. Outputs therefore reset to 0.
- Frame format, LSB first on TDI: bits[1:0] op, [ADDR_W+1:2] addr, [FRAME_W-1:ADDR_W+2] wdata. Ops: 00 NOP, 01 WRITE, 10 READ, 11 CLR_ERR.
- Capture edge (shiftDR=0):
  - shift_reg <= capture word {pad 0s, rdata_reg, rd_valid, err, busy}, with busy in bit0.
  - DATA_W+3 <= FRAME_W always holds.
  - bit_cnt <= 0.
- Shift edge (shiftDR=1):
  - shift_reg <= {scan_in, shift_reg[FRAME_W-1:1]}.
  - bit_cnt increments, saturating at FRAME_W+1.
- Frame commit: happens on the shift edge where bit_cnt goes FRAME_W-1 -> FRAME_W. The frame is the post-shift value, i.e. scan_in concatenated above shift_reg[FRAME_W-1:1].
  - Under-shift (scan exits early): no commit.
  - Over-shift: the edge taking bit_cnt to FRAME_W+1 sets err. The already-committed request stands.
- FSM, states S_IDLE and S_BUSY; busy = (state==S_BUSY):
  - S_IDLE, commit WRITE/READ: latch req_we/addr/wdata, flip req_toggle, go to S_BUSY. A READ also clears rd_valid.
  - S_IDLE, commit CLR_ERR: err <= 0. Commit NOP: no action.
  - S_BUSY, commit of any op other than NOP: dropped, err <= 1. Request fields are unchanged.
  - S_BUSY -> S_IDLE: on the edge where ack_s2 == req_toggle. If req_we==0, rdata_reg <= rdata and rd_valid <= 1 on that same edge.
- ack sync: 2-flop synchronizer (ack_s1, ack_s2) clocked by clockDR.
  - Completion is only observed while clockDR runs, so the host must scan again to poll.
  - Minimum latency: 2 clockDR edges after ack_toggle flips.
- Simultaneous events:
  - Completion and a new commit on the same edge: the commit is evaluated against the pre-edge state, so it is dropped with err=1.
  - err set and CLR_ERR on the same edge: set wins.
- Reset mid-scan or mid-request: everything clears. A core ack arriving after reset is harmless: the synchronizer restarts at 0 and req_toggle=0.

Decomposition:
- Package jtag_pkg: op encodings (OP_NOP, OP_WRITE, OP_READ, OP_CLR_ERR), FSM state constants, capture-word bit positions (ST_BUSY=0, ST_ERR=1, ST_RDV=2, ST_RDATA_LSB=3).
- Sub-module toggle_sync: 2-flop synchronizer with async active-low reset, reusable for other JTAG-to-core crossings.

Test Plan (ADDR_W=8, DATA_W=16, FRAME_W=26):
1. Reset, then capture plus 26 shifts of WRITE addr=0x3C wdata=0xBEEF -> req_toggle 0->1 on the 26th edge; req_we=1, req_addr=0x3C, req_wdata=0xBEEF. The next capture word has bit0=1.
2. Core flips ack_toggle, then the host scans -> busy clears after 2 edges; capture word = 0x0000000 with rd_valid=0.
3. READ addr=0x10, core acks with rdata=0x1234, then the host scans -> capture word bits[18:3]=0x1234, bit2=1, bit0=0. The shifted-out LSBs are 0b100.
4. Second WRITE committed while busy -> req_toggle unchanged, err=1. A later CLR_ERR frame in S_IDLE -> err=0.
5. 20-bit scan (under-shift) -> no req_toggle change. 27-bit scan -> request issued on bit 26, err=1 on bit 27.
6. reset_bar low mid-shift at bit 13 -> all outputs 0 at once (asynchronous). The next full frame commits normally.

Source files
------------

// File: rtl/jtag_mailbox_dr_pkg.sv
// Shared encodings for the JTAG mailbox data register: frame ops, FSM states
// and bit positions of the status word captured into the scan chain.
package jtag_pkg;

    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_WRITE   = 2'b01,
        OP_READ    = 2'b10,
        OP_CLR_ERR = 2'b11
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    localparam int ST_BUSY      = 0;
    localparam int ST_ERR       = 1;
    localparam int ST_RDV       = 2;
    localparam int ST_RDATA_LSB = 3;

endpackage

// File: rtl/jtag_mailbox_dr_if.sv
// Toggle req/ack bundle between the scan-side mailbox (master) and core logic (slave).
interface jtag_mailbox_dr_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              req_toggle;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              ack_toggle;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req_toggle, req_we, req_addr, req_wdata,
        input  ack_toggle, rdata
    );

    modport slave (
        input  req_toggle, req_we, req_addr, req_wdata,
        output ack_toggle, rdata
    );
endinterface

// File: rtl/jtag_mailbox_dr_toggle_sync.sv
// Two-flop synchronizer for a level/toggle signal crossing into the clk domain.
module toggle_sync (
    input  logic clk,
    input  logic reset_bar,
    input  logic async_in,
    output logic sync_out
);
    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= async_in;
            s2_q <= s1_q;
        end
    end

    assign sync_out = s2_q;
endmodule

// File: rtl/jtag_mailbox_dr.sv
// User DR behind the TAP: shifted-in frames become core read/write requests over
// a toggle handshake; the capture word reports busy/err/read data for polling.
module jtag_mailbox_dr
    import jtag_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic clockDR,
    input  logic reset_bar,
    input  logic shiftDR,
    input  logic scan_in,
    output logic scan_out,
    jtag_mailbox_dr_if.master core_if
);
    localparam int FRAME_W = 2 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(FRAME_W + 1);

    state_e              state_q, state_d;
    logic [FRAME_W-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                req_toggle_q, req_toggle_d;
    logic                req_we_q, req_we_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rd_valid_q, rd_valid_d;
    logic                err_q, err_d;

    logic                ack_s2;
    logic                busy;
    logic                commit;
    logic                err_set;
    logic [FRAME_W-1:0]  cap_word;
    op_e                 frame_op;

    toggle_sync u_ack_sync (
        .clk       (clockDR),
        .reset_bar (reset_bar),
        .async_in  (core_if.ack_toggle),
        .sync_out  (ack_s2)
    );

    always_ff @(posedge clockDR or negedge reset_bar) begin
        if (!reset_bar) begin
            state_q      <= S_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            req_toggle_q <= 1'b0;
            req_we_q     <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            rdata_q      <= '0;
            rd_valid_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            req_toggle_q <= req_toggle_d;
            req_we_q     <= req_we_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            rdata_q      <= rdata_d;
            rd_valid_q   <= rd_valid_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        req_toggle_d = req_toggle_q;
        req_we_d     = req_we_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        rdata_d      = rdata_q;
        rd_valid_d   = rd_valid_q;
        err_d        = err_q;

        busy = (state_q == S_BUSY);

        cap_word                            = '0;
        cap_word[ST_BUSY]                   = busy;
        cap_word[ST_ERR]                    = err_q;
        cap_word[ST_RDV]                    = rd_valid_q;
        cap_word[ST_RDATA_LSB +: DATA_W]    = rdata_q;

        if (shiftDR) begin
            shift_d = {scan_in, shift_q[FRAME_W-1:1]};
            if (bit_cnt_q != CNT_OVER) begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end else begin
            shift_d   = cap_word;
            bit_cnt_d = '0;
        end

        frame_op = op_e'(shift_d[1:0]);
        commit   = shiftDR && (bit_cnt_q == CNT_LAST);
        // Commits are judged against the pre-edge state, so one landing on the
        // completion edge is still treated as arriving while busy.
        err_set  = (shiftDR && (bit_cnt_q == CNT_FULL)) ||
                   (commit && busy && (frame_op != OP_NOP));

        if (busy) begin
            if (ack_s2 == req_toggle_q) begin
                state_d = S_IDLE;
                if (!req_we_q) begin
                    rdata_d    = core_if.rdata;
                    rd_valid_d = 1'b1;
                end
            end
        end else if (commit) begin
            case (frame_op)
                OP_WRITE, OP_READ: begin
                    req_we_d     = (frame_op == OP_WRITE);
                    req_addr_d   = shift_d[ADDR_W+1:2];
                    req_wdata_d  = shift_d[FRAME_W-1:ADDR_W+2];
                    req_toggle_d = ~req_toggle_q;
                    state_d      = S_BUSY;
                    if (frame_op == OP_READ) begin
                        rd_valid_d = 1'b0;
                    end
                end
                OP_CLR_ERR: err_d = 1'b0;
                default:    ;
            endcase
        end

        if (err_set) begin
            err_d = 1'b1;
        end
    end

    assign scan_out           = shift_q[0];
    assign core_if.req_toggle = req_toggle_q;
    assign core_if.req_we     = req_we_q;
    assign core_if.req_addr   = req_addr_q;
    assign core_if.req_wdata  = req_wdata_q;
endmodule

// File: tb/tb_jtag_mailbox_dr.sv
// Directed bench for jtag_mailbox_dr: gated clockDR pulses, hand-built frames,
// the bench plays the core side of the toggle handshake.
module tb_jtag_mailbox_dr;
    logic clockDR;
    logic reset_bar;
    logic shiftDR;
    logic scan_in;
    logic scan_out;

    int checks;
    int failures;

    jtag_mailbox_dr_if #(.ADDR_W(8), .DATA_W(16)) mb_if ();

    jtag_mailbox_dr #(.ADDR_W(8), .DATA_W(16)) dut (
        .clockDR   (clockDR),
        .reset_bar (reset_bar),
        .shiftDR   (shiftDR),
        .scan_in   (scan_in),
        .scan_out  (scan_out),
        .core_if   (mb_if)
    );

    function automatic logic [31:0] mk_frame(input logic [1:0] op, input logic [7:0] addr,
                                             input logic [15:0] data);
        return {6'b0, data, addr, op};
    endfunction

    task automatic pulse();
        #5 clockDR = 1'b1;
        #5 clockDR = 1'b0;
    endtask

    task automatic capture_edge();
        shiftDR = 1'b0;
        pulse();
    endtask

    task automatic shift_edge(input logic b);
        shiftDR = 1'b1;
        scan_in = b;
        pulse();
    endtask

    // Capture, then shift n bits of frame; returns the status word shifted out.
    task automatic scan(input logic [31:0] frame, input int n, output logic [25:0] cap);
        capture_edge();
        cap = '0;
        for (int i = 0; i < n; i++) begin
            if (i < 26) cap[i] = scan_out;
            shift_edge(frame[i]);
        end
    endtask

    task automatic test_reset();
        reset_bar = 1'b0;
        #12;
        checks++;
        if ({mb_if.req_toggle, mb_if.req_we, mb_if.req_addr, mb_if.req_wdata, scan_out} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got tog=%0b we=%0b addr=%0h wdata=%0h so=%0b exp all 0",
                     mb_if.req_toggle, mb_if.req_we, mb_if.req_addr, mb_if.req_wdata, scan_out);
        end
        reset_bar = 1'b1;
        #3;
    endtask

    task automatic test_write();
        logic [31:0] f;
        f = mk_frame(2'b01, 8'h3C, 16'hBEEF);
        capture_edge();
        for (int i = 0; i < 25; i++) shift_edge(f[i]);
        checks++;
        if (mb_if.req_toggle !== 1'b0) begin
            failures++;
            $display("FAIL write_pre_commit_toggle got=%0b exp=0", mb_if.req_toggle);
        end
        shift_edge(f[25]);
        checks++;
        if (mb_if.req_toggle !== 1'b1 || mb_if.req_we !== 1'b1 ||
            mb_if.req_addr !== 8'h3C || mb_if.req_wdata !== 16'hBEEF) begin
            failures++;
            $display("FAIL write_commit got tog=%0b we=%0b addr=%0h wdata=%0h exp tog=1 we=1 addr=3c wdata=beef",
                     mb_if.req_toggle, mb_if.req_we, mb_if.req_addr, mb_if.req_wdata);
        end
        capture_edge();
        checks++;
        if (scan_out !== 1'b1) begin
            failures++;
            $display("FAIL write_busy_bit got=%0b exp=1", scan_out);
        end
    endtask

    task automatic test_write_complete();
        logic [25:0] cap;
        mb_if.ack_toggle = 1'b1;
        scan(mk_frame(2'b00, 8'h00, 16'h0000), 26, cap);
        checks++;
        if (cap !== 26'h0000001) begin
            failures++;
            $display("FAIL poll_still_busy got=%07h exp=0000001", cap);
        end
        scan(mk_frame(2'b00, 8'h00, 16'h0000), 26, cap);
        checks++;
        if (cap !== 26'h0000000) begin
            failures++;
            $display("FAIL write_done_status got=%07h exp=0000000", cap);
        end
    endtask

    task automatic test_read();
        logic [25:0] cap;
        scan(mk_frame(2'b10, 8'h10, 16'h0000), 26, cap);
        checks++;
        if (mb_if.req_toggle !== 1'b0 || mb_if.req_we !== 1'b0 || mb_if.req_addr !== 8'h10) begin
            failures++;
            $display("FAIL read_request got tog=%0b we=%0b addr=%0h exp tog=0 we=0 addr=10",
                     mb_if.req_toggle, mb_if.req_we, mb_if.req_addr);
        end
        mb_if.rdata      = 16'h1234;
        mb_if.ack_toggle = 1'b0;
        scan(mk_frame(2'b00, 8'h00, 16'h0000), 26, cap);
        checks++;
        if (cap !== 26'h0000001) begin
            failures++;
            $display("FAIL read_poll_busy got=%07h exp=0000001", cap);
        end
        scan(mk_frame(2'b00, 8'h00, 16'h0000), 26, cap);
        checks++;
        if (cap !== 26'h00091A4) begin
            failures++;
            $display("FAIL read_status_word got=%07h exp=00091a4", cap);
        end
        checks++;
        if (cap[2:0] !== 3'b100) begin
            failures++;
            $display("FAIL read_status_lsbs got=%03b exp=100", cap[2:0]);
        end
    endtask

    task automatic test_busy_write();
        logic [25:0] cap;
        scan(mk_frame(2'b01, 8'hA5, 16'h5555), 26, cap);
        checks++;
        if (mb_if.req_toggle !== 1'b1 || mb_if.req_addr !== 8'hA5 || mb_if.req_wdata !== 16'h5555) begin
            failures++;
            $display("FAIL busy_first_write got tog=%0b addr=%0h wdata=%0h exp tog=1 addr=a5 wdata=5555",
                     mb_if.req_toggle, mb_if.req_addr, mb_if.req_wdata);
        end
        scan(mk_frame(2'b01, 8'h22, 16'h1111), 26, cap);
        checks++;
        if (mb_if.req_toggle !== 1'b1 || mb_if.req_addr !== 8'hA5 || mb_if.req_wdata !== 16'h5555 ||
            mb_if.req_we !== 1'b1) begin
            failures++;
            $display("FAIL busy_dropped_write got tog=%0b addr=%0h wdata=%0h exp tog=1 addr=a5 wdata=5555",
                     mb_if.req_toggle, mb_if.req_addr, mb_if.req_wdata);
        end
        mb_if.ack_toggle = 1'b1;
        scan(mk_frame(2'b00, 8'h00, 16'h0000), 26, cap);
        checks++;
        if (cap !== 26'h00091A7) begin
            failures++;
            $display("FAIL busy_err_status got=%07h exp=00091a7", cap);
        end
        scan(mk_frame(2'b11, 8'h00, 16'h0000), 26, cap);
        checks++;
        if (cap !== 26'h00091A6) begin
            failures++;
            $display("FAIL idle_err_status got=%07h exp=00091a6", cap);
        end
        scan(mk_frame(2'b00, 8'h00, 16'h0000), 26, cap);
        checks++;
        if (cap !== 26'h00091A4) begin
            failures++;
            $display("FAIL clr_err_status got=%07h exp=00091a4", cap);
        end
    endtask

    task automatic test_under_over();
        logic [25:0] cap;
        logic [31:0] f;
        f = mk_frame(2'b01, 8'h77, 16'hCAFE);
        scan(f, 20, cap);
        checks++;
        if (mb_if.req_toggle !== 1'b1) begin
            failures++;
            $display("FAIL under_shift_toggle got=%0b exp=1", mb_if.req_toggle);
        end
        scan(mk_frame(2'b00, 8'h00, 16'h0000), 26, cap);
        checks++;
        if (cap !== 26'h00091A4) begin
            failures++;
            $display("FAIL under_shift_status got=%07h exp=00091a4", cap);
        end
        scan(f, 26, cap);
        checks++;
        if (mb_if.req_toggle !== 1'b0 || mb_if.req_addr !== 8'h77 || mb_if.req_wdata !== 16'hCAFE) begin
            failures++;
            $display("FAIL over_shift_commit got tog=%0b addr=%0h wdata=%0h exp tog=0 addr=77 wdata=cafe",
                     mb_if.req_toggle, mb_if.req_addr, mb_if.req_wdata);
        end
        shift_edge(1'b1);
        mb_if.ack_toggle = 1'b0;
        scan(mk_frame(2'b11, 8'h00, 16'h0000), 26, cap);
        checks++;
        if (cap !== 26'h00091A7) begin
            failures++;
            $display("FAIL over_shift_err got=%07h exp=00091a7", cap);
        end
        checks++;
        if (mb_if.req_toggle !== 1'b0 || mb_if.req_addr !== 8'h77) begin
            failures++;
            $display("FAIL over_shift_request_kept got tog=%0b addr=%0h exp tog=0 addr=77",
                     mb_if.req_toggle, mb_if.req_addr);
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [25:0] cap;
        logic [31:0] f;
        f = mk_frame(2'b01, 8'h81, 16'h0F0F);
        capture_edge();
        for (int i = 0; i < 13; i++) shift_edge(f[i]);
        reset_bar = 1'b0;
        #1;
        checks++;
        if ({mb_if.req_toggle, mb_if.req_we, mb_if.req_addr, mb_if.req_wdata, scan_out} !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs got tog=%0b we=%0b addr=%0h wdata=%0h so=%0b exp all 0",
                     mb_if.req_toggle, mb_if.req_we, mb_if.req_addr, mb_if.req_wdata, scan_out);
        end
        #4 reset_bar = 1'b1;
        #2;
        scan(f, 26, cap);
        checks++;
        if (cap !== 26'h0000000) begin
            failures++;
            $display("FAIL post_reset_status got=%07h exp=0000000", cap);
        end
        checks++;
        if (mb_if.req_toggle !== 1'b1 || mb_if.req_we !== 1'b1 ||
            mb_if.req_addr !== 8'h81 || mb_if.req_wdata !== 16'h0F0F) begin
            failures++;
            $display("FAIL post_reset_commit got tog=%0b we=%0b addr=%0h wdata=%0h exp tog=1 we=1 addr=81 wdata=0f0f",
                     mb_if.req_toggle, mb_if.req_we, mb_if.req_addr, mb_if.req_wdata);
        end
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        clockDR          = 1'b0;
        reset_bar        = 1'b1;
        shiftDR          = 1'b0;
        scan_in          = 1'b0;
        mb_if.ack_toggle = 1'b0;
        mb_if.rdata      = '0;
        #2;
        test_reset();
        test_write();
        test_write_complete();
        test_read();
        test_busy_write();
        test_under_over();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
